store_buffer: RTL and testbench

- Commit-side store FIFO sitting directly downstream of the reorder buffer's dCache write interface.
- Accepts one retired store per cycle (address, data, byte flag) and holds it until the dCache accepts it.
- Drains entries to the dCache in program order, one request at a time.
- Produces a full indication so the reorder buffer stalls commit of further stores.

---
 rtl/store_buffer.sv | 134 +++++++++++++
 tb/tb_store_buffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Commit-side store FIFO draining retired stores to the dCache in program order.
// Define SB_FORWARD_EN to enable store-to-load forwarding from buffered entries.
module store_buffer #(
    parameter int unsigned ARCH_BITS   = 32,
    parameter int unsigned SB_SLOTS    = 4,
    parameter int unsigned SB_IDX_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wEnableMem,
    input  logic [ARCH_BITS-1:0] wAddressMem,
    input  logic [ARCH_BITS-1:0] wDataMem,
    input  logic                 wByteMem,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 memReq,
    output logic [ARCH_BITS-1:0] memAddr,
    output logic [ARCH_BITS-1:0] memData,
    output logic                 memByte,
    input  logic                 memAck,
    input  logic [ARCH_BITS-1:0] ldAddr,
    input  logic                 ldByte,
    output logic                 ldHit,
    output logic [ARCH_BITS-1:0] ldData,
    output logic                 ldConflict
);

    logic [SB_SLOTS-1:0]    valid_q;
    logic [ARCH_BITS-1:0]   addr_q  [SB_SLOTS];
    logic [ARCH_BITS-1:0]   data_q  [SB_SLOTS];
    logic [SB_SLOTS-1:0]    bflag_q;
    logic [SB_IDX_BITS-1:0] head_q, tail_q;
    logic [SB_IDX_BITS:0]   count_q;
    logic                   overflow_q;
    logic                   push, pop;

    // Full is taken from the pre-edge count, so a pop never makes room for a same-cycle push.
    assign full     = (count_q == (SB_IDX_BITS + 1)'(SB_SLOTS));
    assign empty    = (count_q == '0);
    assign overflow = overflow_q;
    assign push     = wEnableMem && !full;
    assign pop      = valid_q[head_q] && memAck;

    assign memReq  = valid_q[head_q];
    assign memAddr = addr_q[head_q];
    assign memData = data_q[head_q];
    assign memByte = bflag_q[head_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wEnableMem && full) begin
                overflow_q <= 1'b1;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Payload needs no reset: it is only observed behind a set valid bit.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q]  <= wAddressMem;
            data_q[tail_q]  <= wDataMem;
            bflag_q[tail_q] <= wByteMem;
        end
    end

`ifdef SB_FORWARD_EN
    logic                   fwd_match;
    logic [SB_IDX_BITS-1:0] fwd_idx;
    logic [SB_IDX_BITS-1:0] scan_idx;
    logic [ARCH_BITS-1:0]   fwd_word;
    logic [7:0]             fwd_lane;

    // Scan oldest to youngest so the last match found is the youngest store.
    always_comb begin
        fwd_match = 1'b0;
        fwd_idx   = head_q;
        scan_idx  = head_q;
        for (int i = 0; i < int'(SB_SLOTS); i++) begin
            scan_idx = head_q + SB_IDX_BITS'(i);
            if (valid_q[scan_idx] &&
                addr_q[scan_idx][ARCH_BITS-1:2] == ldAddr[ARCH_BITS-1:2]) begin
                fwd_match = 1'b1;
                fwd_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        fwd_word   = data_q[fwd_idx];
        fwd_lane   = 8'(fwd_word >> {ldAddr[1:0], 3'b000});
        ldHit      = 1'b0;
        ldConflict = 1'b0;
        ldData     = '0;
        if (fwd_match) begin
            if (!bflag_q[fwd_idx]) begin
                ldHit  = 1'b1;
                ldData = ldByte ? ARCH_BITS'(fwd_lane) : fwd_word;
            end else if (ldByte && addr_q[fwd_idx] == ldAddr) begin
                ldHit  = 1'b1;
                ldData = ARCH_BITS'(fwd_word[7:0]);
            end else begin
                ldConflict = 1'b1;
            end
        end
    end
`else
    logic unused_ld;
    assign unused_ld  = ^{ldAddr, ldByte};
    assign ldHit      = 1'b0;
    assign ldConflict = 1'b0;
    assign ldData     = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: directed scenarios plus random push/ack traffic
// checked against a queue-based reference model.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wEnableMem = 1'b0;
    logic [31:0] wAddressMem = '0;
    logic [31:0] wDataMem = '0;
    logic        wByteMem = 1'b0;
    logic        full, empty, overflow, memReq, memByte;
    logic [31:0] memAddr, memData;
    logic        memAck = 1'b0;
    logic [31:0] ldAddr = '0;
    logic        ldByte = 1'b0;
    logic        ldHit, ldConflict;
    logic [31:0] ldData;

    store_buffer #(
        .ARCH_BITS   (32),
        .SB_SLOTS    (4),
        .SB_IDX_BITS (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wEnableMem  (wEnableMem),
        .wAddressMem (wAddressMem),
        .wDataMem    (wDataMem),
        .wByteMem    (wByteMem),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .memReq      (memReq),
        .memAddr     (memAddr),
        .memData     (memData),
        .memByte     (memByte),
        .memAck      (memAck),
        .ldAddr      (ldAddr),
        .ldByte      (ldByte),
        .ldHit       (ldHit),
        .ldData      (ldData),
        .ldConflict  (ldConflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        bflag;
    } entry_t;

    // Scoreboard: stores accepted by the model, oldest first, still awaiting the dCache.
    entry_t exp_q[$];
    int     model_cnt = 0;
    logic   model_ovf = 1'b0;
    int     n_tests = 0;
    int     n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_cnt = 0;
        model_ovf = 1'b0;
    endtask

    // Apply one cycle of stimulus, then advance the model at the same edge the DUT samples.
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic b, input logic ack, input logic [31:0] la, input logic lb);
        entry_t e;
        bit     do_push, do_pop;
        wEnableMem  = we;
        wAddressMem = a;
        wDataMem    = d;
        wByteMem    = b;
        memAck      = ack;
        ldAddr      = la;
        ldByte      = lb;
        @(posedge clk);
        if (!rst) begin
            do_push = we && (model_cnt < 4);
            do_pop  = ack && (model_cnt > 0);
            if (we && model_cnt == 4) model_ovf = 1'b1;
            if (do_push) begin
                e.addr  = a;
                e.data  = d;
                e.bflag = b;
                exp_q.push_back(e);
            end
            model_cnt = model_cnt + int'(do_push) - int'(do_pop);
        end
        #1;
    endtask

    task automatic idle(input logic ack);
        step(1'b0, 32'h0, 32'h0, 1'b0, ack, 32'h0, 1'b0);
    endtask

`ifdef SB_FORWARD_EN
    function automatic void fwd_model(output logic hit, output logic conf,
                                      output logic [31:0] dat);
        hit  = 1'b0;
        conf = 1'b0;
        dat  = '0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].addr[31:2] == ldAddr[31:2]) begin
                if (!exp_q[i].bflag) begin
                    hit = 1'b1;
                    dat = ldByte ? ((exp_q[i].data >> (8 * ldAddr[1:0])) & 32'hFF)
                                 : exp_q[i].data;
                end else if (ldByte && exp_q[i].addr == ldAddr) begin
                    hit = 1'b1;
                    dat = {24'h0, exp_q[i].data[7:0]};
                end else begin
                    conf = 1'b1;
                end
                break;
            end
        end
    endfunction
`endif

    // Monitor: samples mid-cycle, compares status and lookups, and retires acked requests.
    always @(negedge clk) begin
        entry_t      h;
        logic        e_hit, e_conf;
        logic [31:0] e_dat;
        if (!rst) begin
            check("memReq", 32'(memReq), 32'(model_cnt > 0));
            check("empty", 32'(empty), 32'(model_cnt == 0));
            check("full", 32'(full), 32'(model_cnt == 4));
            check("overflow", 32'(overflow), 32'(model_ovf));
`ifdef SB_FORWARD_EN
            fwd_model(e_hit, e_conf, e_dat);
`else
            e_hit  = 1'b0;
            e_conf = 1'b0;
            e_dat  = '0;
`endif
            check("ldHit", 32'(ldHit), 32'(e_hit));
            check("ldConflict", 32'(ldConflict), 32'(e_conf));
            check("ldData", ldData, e_dat);
            if (memReq && memAck) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 32'(memReq), 32'h0);
                end else begin
                    h = exp_q.pop_front();
                    check("memAddr", memAddr, h.addr);
                    check("memData", memData, h.data);
                    check("memByte", 32'(memByte), 32'(h.bflag));
                end
            end
        end
    end

    initial begin
        logic [31:0] a, la;
        logic        b, we, ack;
        int          wp, ap;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        repeat (5) idle(1'b0);

        // Single store then single ack
        step(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill, overflow, ordered drain
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
        end
        repeat (4) idle(1'b1);
        idle(1'b0);

        // Simultaneous push/pop holding two entries, pointers wrap twice
        step(1'b1, 32'h200, 32'h1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h204, 32'h2, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h208 + 32'(4 * i), 32'h10 + 32'(i), 1'(i), 1'b1, 32'h0, 1'b0);
        end
        repeat (2) idle(1'b1);

        // Async reset mid-drain with three entries held
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h300 + 32'(4 * i), 32'h55 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
        end
        idle(1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_memReq", 32'(memReq), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_ldHit", 32'(ldHit), 32'h0);
        check("rst_ldConflict", 32'(ldConflict), 32'h0);
        model_reset();
        #1 rst = 1'b0;
        step(1'b1, 32'h400, 32'h0BAD_CAFE, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Forwarding lookups: word hit by byte load, byte store vs word load
        step(1'b1, 32'h100, 32'h1122_3344, 1'b0, 1'b0, 32'h102, 1'b1);
        step(1'b1, 32'h104, 32'h0000_00AA, 1'b1, 1'b0, 32'h102, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h104, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h104, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0);
        repeat (2) idle(1'b1);

        // Random traffic in phases of differing push/ack pressure
        for (int p = 0; p < 8; p++) begin
            wp = int'($urandom_range(20, 95));
            ap = int'($urandom_range(10, 90));
            for (int c = 0; c < 100; c++) begin
                we  = ($urandom % 100) < wp;
                ack = ($urandom % 100) < ap;
                b   = $urandom_range(0, 1) == 1;
                a   = 32'h100 + (32'($urandom_range(0, 7)) << 2);
                if (b) a = a + 32'($urandom_range(0, 3));
                la  = 32'h100 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
                step(we, a, $urandom, b, ack, la, $urandom_range(0, 1) == 1);
            end
        end
        repeat (6) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
